// File: rtl/cam_config_sequencer_if.sv
// Register-write command channel between the config sequencer and the SCCB master.
interface cam_config_sequencer_if #(
  parameter int unsigned REG_W  = 8,
  parameter int unsigned DATA_W = 8
) ();

  logic              wr_valid;
  logic [REG_W-1:0]  wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              wr_done;
  logic              wr_nack;

  // Sequencer side: issues commands, observes acceptance and completion.
  modport master (
    output wr_valid,
    output wr_reg,
    output wr_data,
    input  wr_ready,
    input  wr_done,
    input  wr_nack
  );

  // SCCB master side.
  modport slave (
    input  wr_valid,
    input  wr_reg,
    input  wr_data,
    output wr_ready,
    output wr_done,
    output wr_nack
  );

endinterface

// File: rtl/cam_config_sequencer.sv
// Camera register-configuration sequencer: walks a registered config ROM from
// a base entry, decodes end/delay markers and issues each register write to
// the SCCB master with bounded NACK retry.
module cam_config_sequencer #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned REG_W        = 8,
  parameter int unsigned DATA_W       = 8,
  parameter logic [REG_W+DATA_W-1:0] END_MARK   = '1,
  parameter logic [REG_W+DATA_W-1:0] DELAY_MARK = (REG_W+DATA_W)'(16'hFFF0),
  parameter int unsigned DELAY_CYCLES = 1_000_000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [REG_W+DATA_W-1:0]   rom_data,
  cam_config_sequencer_if.master    wr_if,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [1:0]                err_code
);

  localparam int unsigned DLY_W   = (DELAY_CYCLES < 2) ? 1 : $clog2(DELAY_CYCLES);
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_ACK,
    S_DELAY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_index;
  logic [RETRY_W-1:0]  r_retry;
  logic [DLY_W-1:0]    r_dly;

  logic w_advance;
  logic w_last;

  // Entry finished (clean ack or delay expired): move to the next ROM index.
  assign w_advance = ((r_state == S_WAIT_ACK) && wr_if.wr_done && !wr_if.wr_nack) ||
                     ((r_state == S_DELAY) && (r_dly == DLY_W'(0)));
  assign w_last    = (r_index == {ADDR_W{1'b1}});

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_index        <= '0;
      r_retry        <= '0;
      r_dly          <= '0;
      rom_en         <= 1'b0;
      rom_addr       <= '0;
      wr_if.wr_valid <= 1'b0;
      wr_if.wr_reg   <= '0;
      wr_if.wr_data  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_code       <= 2'd0;
    end else if (w_advance) begin
      // The table does not wrap: running off the end is an abort.
      if (w_last) begin
        error    <= 1'b1;
        err_code <= 2'd2;
        busy     <= 1'b0;
        r_state  <= S_ERROR;
      end else begin
        r_index  <= r_index + ADDR_W'(1);
        rom_addr <= r_index + ADDR_W'(1);
        rom_en   <= 1'b1;
        r_state  <= S_FETCH;
      end
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_index  <= base_addr;
            rom_addr <= base_addr;
            rom_en   <= 1'b1;
            r_retry  <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'd0;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          rom_en  <= 1'b0;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (rom_data == END_MARK) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else if (rom_data == DELAY_MARK) begin
            r_dly   <= DLY_W'(DELAY_CYCLES - 1);
            r_state <= S_DELAY;
          end else begin
            wr_if.wr_reg   <= rom_data[REG_W+DATA_W-1:DATA_W];
            wr_if.wr_data  <= rom_data[DATA_W-1:0];
            wr_if.wr_valid <= 1'b1;
            r_retry        <= '0;
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (wr_if.wr_ready) begin
            wr_if.wr_valid <= 1'b0;
            r_state        <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          // Clean acks are handled by the advance path above.
          if (wr_if.wr_done && wr_if.wr_nack) begin
            if (r_retry < RETRY_W'(MAX_RETRY)) begin
              r_retry        <= r_retry + RETRY_W'(1);
              wr_if.wr_valid <= 1'b1;
              r_state        <= S_ISSUE;
            end else begin
              error    <= 1'b1;
              err_code <= 2'd1;
              busy     <= 1'b0;
              r_state  <= S_ERROR;
            end
          end
        end
        S_DELAY: begin
          r_dly <= r_dly - DLY_W'(1);
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_config_sequencer.sv
// Scoreboard bench for cam_config_sequencer: a behavioural model walks the ROM
// table to predict fetch addresses, write commands and the final status.
module tb_cam_config_sequencer;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned REG_W  = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DLY    = 16;
  localparam int unsigned MAXR   = 2;
  localparam logic [15:0] END_W  = 16'hFFFF;
  localparam logic [15:0] DLY_M  = 16'hFFF0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              busy, done, error;
  logic [1:0]        err_code;

  cam_config_sequencer_if #(.REG_W(REG_W), .DATA_W(DATA_W)) wr_if ();

  cam_config_sequencer #(
    .ADDR_W(ADDR_W), .REG_W(REG_W), .DATA_W(DATA_W),
    .END_MARK(END_W), .DELAY_MARK(DLY_M),
    .DELAY_CYCLES(DLY), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .wr_if(wr_if),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input longint act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event, value 0x%0h at %0t", name, act, $time);
  endtask

  // Registered config ROM.
  logic [15:0] rom [DEPTH];
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  // Scoreboard queues and master behaviour knobs.
  int          exp_addr[$];
  logic [15:0] exp_wr[$];
  bit          plan[$];
  int          plan_k;
  int          ack_lat = 2;
  int          bp_hold = 0;
  bit          ready_always = 1'b1;
  int          pending = 0;

  // SCCB master model: ready policy, ack latency, nack plan, stray done pulses.
  initial begin
    wr_if.wr_ready = 1'b0;
    wr_if.wr_done  = 1'b0;
    wr_if.wr_nack  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      wr_if.wr_done = 1'b0;
      wr_if.wr_nack = 1'b0;
      if (!rst_n) begin
        pending = 0;
        wr_if.wr_ready = 1'b0;
        continue;
      end
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          wr_if.wr_done = 1'b1;
          wr_if.wr_nack = (plan_k < plan.size()) ? plan[plan_k] : 1'b0;
          plan_k++;
        end
      end
      if (wr_if.wr_valid && bp_hold > 0) begin
        wr_if.wr_ready = 1'b0;
        bp_hold--;
      end else begin
        wr_if.wr_ready = ready_always ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
      if (wr_if.wr_valid && wr_if.wr_ready) begin
        pending = ack_lat;
      end else if (wr_if.wr_valid && !wr_if.wr_done && pending == 0 &&
                   $urandom_range(0, 3) == 0) begin
        wr_if.wr_done = 1'b1;
        wr_if.wr_nack = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: compares every fetch and every accepted command against the queues.
  int          cyc = 0;
  int          last_fetch_cyc;
  int          last_fetch_addr;
  bit          have_last = 1'b0;
  int          stall_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_cmd;
  logic [15:0] cmd;

  always @(negedge clk) begin
    cyc++;
    cmd = {wr_if.wr_reg, wr_if.wr_data};
    if (!rst_n) begin
      prev_stall = 1'b0;
      have_last  = 1'b0;
    end else begin
      if (rom_en) begin
        if (exp_addr.size() == 0) flag("rom_en_extra", rom_addr);
        else chk("rom_addr", rom_addr, exp_addr.pop_front());
        if (have_last && rom[last_fetch_addr] == DLY_M)
          chk("delay_gap", cyc - last_fetch_cyc, DLY + 2);
        have_last       = 1'b1;
        last_fetch_addr = int'(rom_addr);
        last_fetch_cyc  = cyc;
      end
      if (wr_if.wr_valid && wr_if.wr_ready) begin
        if (exp_wr.size() == 0) flag("wr_extra", cmd);
        else chk("wr_cmd", cmd, exp_wr.pop_front());
      end
      if (prev_stall) begin
        if (!wr_if.wr_valid) flag("wr_valid_dropped", prev_cmd);
        else chk("wr_stable", cmd, prev_cmd);
      end
      prev_stall = wr_if.wr_valid && !wr_if.wr_ready;
      prev_cmd   = cmd;
      if (prev_stall) stall_cnt++;
    end
  end

  // Reference model: walk the table by the sequencer's rules and predict
  // fetches, writes (including retries) and the final status code.
  task automatic model(input int base, output int exp_err);
    int idx;
    int k;
    bit n;
    idx = base;
    k = 0;
    exp_err = 0;
    forever begin
      exp_addr.push_back(idx);
      if (rom[idx] == END_W) begin
        exp_err = 0;
        return;
      end
      if (rom[idx] != DLY_M) begin
        for (int a = 0; a <= int'(MAXR); a++) begin
          exp_wr.push_back(rom[idx]);
          n = (k < plan.size()) ? plan[k] : 1'b0;
          k++;
          if (!n) break;
          if (a == int'(MAXR)) begin
            exp_err = 1;
            return;
          end
        end
      end
      if (idx == int'(DEPTH) - 1) begin
        exp_err = 2;
        return;
      end
      idx++;
    end
  endtask

  function automatic logic [15:0] rand_regular();
    return {8'($urandom_range(0, 254)), 8'($urandom)};
  endfunction

  task automatic set_plan(input int pct_nack);
    plan.delete();
    for (int i = 0; i < 48; i++) plan.push_back($urandom_range(0, 99) < pct_nack);
  endtask

  task automatic prep(input int lat, input bit rdy, input int bp);
    exp_addr.delete();
    exp_wr.delete();
    plan_k       = 0;
    ack_lat      = lat;
    ready_always = rdy;
    bp_hold      = bp;
    stall_cnt    = 0;
    have_last    = 1'b0;
  endtask

  task automatic pulse_start(input int base);
    @(negedge clk);
    base_addr = ADDR_W'(base);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base_addr = ADDR_W'($urandom);
  endtask

  // One full sequence: predict, start, wait for completion, check status.
  task automatic run_seq(input int base, input int lat, input bit rdy, input int bp,
                         input bit extra_start);
    int exp_err;
    int n;
    prep(lat, rdy, bp);
    model(base, exp_err);
    pulse_start(base);
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    chk("error_cleared", error, 0);
    n = 0;
    while (!(done || error) && n < 3000) begin
      @(negedge clk);
      n++;
      if (extra_start && n == 6) begin
        base_addr = ADDR_W'(base + 3);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (n >= 3000) flag("timeout", n);
    chk("done", done, exp_err == 0);
    chk("error", error, exp_err != 0);
    chk("err_code", err_code, exp_err);
    chk("busy_end", busy, 0);
    repeat (4) @(negedge clk);
    chk("addr_left", exp_addr.size(), 0);
    chk("wr_left", exp_wr.size(), 0);
    chk("status_held", {done, error, err_code}, {exp_err == 0, exp_err != 0, 2'(exp_err)});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rom_en"}, rom_en, 0);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_wr_valid"}, wr_if.wr_valid, 0);
    chk({tag, "_wr_cmd"}, {wr_if.wr_reg, wr_if.wr_data}, 0);
    chk({tag, "_status"}, {busy, done, error, err_code}, 0);
  endtask

  task automatic load_basic();
    for (int i = 0; i < int'(DEPTH); i++) rom[i] = rand_regular();
    rom[0] = 16'h1280;
    rom[1] = DLY_M;
    rom[2] = 16'h1101;
    rom[3] = END_W;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    for (int i = 0; i < int'(DEPTH); i++) rom[i] = END_W;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Basic sequence with a delay marker.
    load_basic();
    set_plan(0);
    run_seq(0, 2, 1'b1, 0, 1'b0);

    // Backpressure on the first entry.
    set_plan(0);
    run_seq(0, 2, 1'b1, 5, 1'b0);
    chk("stall_cycles", stall_cnt, 5);

    // Every write NACKed: initial issue plus MAX_RETRY re-issues, then abort.
    rom[0] = 16'h1234;
    set_plan(100);
    run_seq(0, 2, 1'b1, 0, 1'b0);

    // No end marker: runs off the table.
    for (int i = 0; i < int'(DEPTH); i++) rom[i] = rand_regular();
    set_plan(0);
    run_seq(0, 1, 1'b1, 0, 1'b0);

    // Base select with a stray start while busy.
    rom[6] = END_W;
    set_plan(0);
    run_seq(4, 3, 1'b1, 0, 1'b1);

    // Reset while in DELAY, then a full rerun.
    load_basic();
    set_plan(0);
    prep(2, 1'b1, 0);
    begin
      int dummy;
      model(0, dummy);
    end
    pulse_start(0);
    n = 0;
    while (!(have_last && last_fetch_addr == 1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) flag("timeout_delay_fetch", n);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_delay_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(0, 2, 1'b1, 0, 1'b0);

    // Randomised tables, bases, nack plans and handshake timing.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        case ($urandom_range(0, 9))
          0: rom[i] = DLY_M;
          1: rom[i] = END_W;
          default: rom[i] = rand_regular();
        endcase
      end
      set_plan(30);
      run_seq(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 4)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
